// File: rtl/riscv_dcache_fsm.sv
// Write-back direct-mapped data-cache controller: IDLE / WRITEBACK / ALLOCATE.
// Optional perf counters are built when DCACHE_PERF_CNT_EN is defined.
module riscv_dcache_fsm
`ifdef DCACHE_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic             hit,
    input  logic             dirty,
    input  logic             mem_ready,
    output logic             stall,
    output logic             replace_tag,
    output logic             valid_out,
    output logic             dirty_out,
    output logic             cache_wr,
    output logic             fill,
    output logic             mem_req,
    output logic             mem_we,
`ifdef DCACHE_PERF_CNT_EN
    output logic             wb_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
`else
    output logic             wb_sel
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t r_state;
    logic   w_req;
    logic   w_idle_hit;
    logic   w_idle_miss;
    logic   w_refill_done;

    assign w_req         = cpu_rd | cpu_wr;
    assign w_idle_hit    = (r_state == S_IDLE) && w_req && hit;
    assign w_idle_miss   = (r_state == S_IDLE) && w_req && !hit;
    assign w_refill_done = (r_state == S_ALLOCATE) && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req && !hit)
                        r_state <= dirty ? S_WRITEBACK : S_ALLOCATE;
                end
                S_WRITEBACK: begin
                    if (mem_ready)
                        r_state <= S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    if (mem_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst_n so they read 0 while reset is held.
    always_comb begin
        stall       = 1'b0;
        replace_tag = 1'b0;
        valid_out   = 1'b0;
        dirty_out   = 1'b0;
        cache_wr    = 1'b0;
        fill        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        wb_sel      = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_idle_hit && cpu_wr) begin
                        cache_wr    = 1'b1;
                        replace_tag = 1'b1;
                        valid_out   = 1'b1;
                        dirty_out   = 1'b1;
                    end
                    if (w_idle_miss)
                        stall = 1'b1;
                end
                S_WRITEBACK: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    wb_sel  = 1'b1;
                end
                S_ALLOCATE: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        fill        = 1'b1;
                        replace_tag = 1'b1;
                        valid_out   = 1'b1;
                    end
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic             r_refill_done;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;

    // The re-lookup right after a refill is the same access, not a new hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refill_done <= 1'b0;
            r_hit_count   <= '0;
            r_miss_count  <= '0;
        end else begin
            r_refill_done <= w_refill_done;
            if (w_idle_hit && !r_refill_done && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_idle_miss && (r_miss_count != '1))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    logic w_unused;
    assign w_unused = w_refill_done;
`endif

endmodule

// File: tb/tb_riscv_dcache_fsm.sv
// Directed vector bench for riscv_dcache_fsm.
// Output vector order: stall,replace_tag,valid_out,dirty_out,cache_wr,fill,mem_req,mem_we,wb_sel.
module tb_riscv_dcache_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rd = 1'b0;
    logic cpu_wr = 1'b0;
    logic hit = 1'b0;
    logic dirty = 1'b0;
    logic mem_ready = 1'b0;
    logic stall, replace_tag, valid_out, dirty_out;
    logic cache_wr, fill, mem_req, mem_we, wb_sel;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_dcache_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .hit         (hit),
        .dirty       (dirty),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .replace_tag (replace_tag),
        .valid_out   (valid_out),
        .dirty_out   (dirty_out),
        .cache_wr    (cache_wr),
        .fill        (fill),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
`ifdef DCACHE_PERF_CNT_EN
        .wb_sel      (wb_sel),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`else
        .wb_sel      (wb_sel)
`endif
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic       h;
        logic       d;
        logic       mr;
        logic [8:0] exp;
    } vec_t;

    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_STALL = 9'b100000000;
    localparam logic [8:0] O_STHIT = 9'b011110000;
    localparam logic [8:0] O_WB    = 9'b100000111;
    localparam logic [8:0] O_ALLOC = 9'b100000100;
    localparam logic [8:0] O_FILL  = 9'b111001100;

    vec_t vecs[18];

    function automatic logic [8:0] outs();
        return {stall, replace_tag, valid_out, dirty_out,
                cache_wr, fill, mem_req, mem_we, wb_sel};
    endfunction

    task automatic check(input string name, input logic [8:0] got,
                         input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic h,
                         input logic d, input logic mr);
        cpu_rd    = rd;
        cpu_wr    = wr;
        hit       = h;
        dirty     = d;
        mem_ready = mr;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_STHIT};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_STHIT};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_ALLOC};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_ALLOC};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_ALLOC};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_FILL};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_STALL};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_WB};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_WB};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_WB};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_ALLOC};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, O_FILL};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_STHIT};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};

        // Reset held with a store hit presented: outputs must stay low.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #3;
        check("reset_outputs", outs(), O_NONE);
`ifdef DCACHE_PERF_CNT_EN
        check("reset_hit_count", hit_count[8:0], 9'd0);
        check("reset_miss_count", miss_count[8:0], 9'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].h, vecs[i].d, vecs[i].mr);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            @(posedge clk);
            #1;
        end

`ifdef DCACHE_PERF_CNT_EN
        check("hit_count", hit_count[8:0], 9'd3);
        check("miss_count", miss_count[8:0], 9'd2);
`endif

        // Reset asserted mid-writeback, no clock edge in between.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("wb_before_reset", outs(), O_WB);
        rst_n = 1'b0;
        #1;
        check("async_reset_wb", outs(), O_NONE);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_reset_idle_miss", outs(), O_STALL);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("post_reset_idle_hit", outs(), O_NONE);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("idle_mem_ready", outs(), O_NONE);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("idle_after_stray_ready", outs(), O_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
